// File: rtl/add_pkg.sv
// Shared widths and request/response bundles for the registered add stage.
package add_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int BLOCK_SIZE = 16;
    localparam int CNT_WIDTH  = 16;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  cin;
    } add_req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] sum;
        logic                  cout;
        logic                  ovf;
    } add_rsp_t;
endpackage

// File: rtl/CSA_ADDER3.sv
// Combinational carry-select adder: each block precomputes both carry-in
// cases and the incoming block carry picks one.
module CSA_ADDER3 #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout
);
    localparam int NB = DATA_WIDTH / BLOCK_SIZE;

    logic [NB:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[NB];

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLOCK_SIZE:0] s0;
        logic [BLOCK_SIZE:0] s1;
        logic [BLOCK_SIZE-1:0] ba;
        logic [BLOCK_SIZE-1:0] bb;

        assign ba = a[g*BLOCK_SIZE +: BLOCK_SIZE];
        assign bb = b[g*BLOCK_SIZE +: BLOCK_SIZE];
        assign s0 = {1'b0, ba} + {1'b0, bb};
        assign s1 = {1'b0, ba} + {1'b0, bb} + (BLOCK_SIZE+1)'(1);

        assign sum[g*BLOCK_SIZE +: BLOCK_SIZE] =
            carry[g] ? s1[BLOCK_SIZE-1:0] : s0[BLOCK_SIZE-1:0];
        assign carry[g+1] = carry[g] ? s1[BLOCK_SIZE] : s0[BLOCK_SIZE];
    end
endmodule

// File: rtl/add_stream_stage.sv
// Two-stage valid/ready wrapper around CSA_ADDER3.
// ADD_STREAM_OVF_EN adds a registered signed-overflow flag on out_ovf.
module add_stream_stage
    import add_pkg::*;
#(
    parameter int DATA_WIDTH = add_pkg::DATA_WIDTH,
    parameter int BLOCK_SIZE = add_pkg::BLOCK_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_cout,
    output logic                  out_ovf,
    output logic [CNT_WIDTH-1:0]  txn_cnt
);
    localparam int MSB = DATA_WIDTH - 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  cin;
    } req_t;

    req_t                  s1;
    logic                  v1;
    logic                  v2;
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  cout_q;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] add_sum;
    logic                  add_cout;
    logic                  adv1;
    logic                  adv2;

    CSA_ADDER3 #(
        .DATA_WIDTH(DATA_WIDTH),
        .BLOCK_SIZE(BLOCK_SIZE)
    ) u_adder (
        .a   (s1.a),
        .b   (s1.b),
        .cin (s1.cin),
        .sum (add_sum),
        .cout(add_cout)
    );

    // No skid buffer: ready ripples back combinationally from out_ready.
    assign adv2     = !v2 || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else if (flush) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            cnt <= '0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1 <= '{a: in_a, b: in_b, cin: in_cin};
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    sum_q  <= add_sum;
                    cout_q <= add_cout;
                end
            end
            if (v2 && out_ready) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef ADD_STREAM_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (!flush && adv2 && v1) begin
            ovf_q <= (s1.a[MSB] == s1.b[MSB]) && (add_sum[MSB] != s1.a[MSB]);
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    assign out_valid = v2;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign txn_cnt   = cnt;
endmodule
